// File: rtl/period_meter.sv
// period_meter
//   Measures the period of an asynchronous input signal in clock_in cycles,
//   rejects glitch edges that arrive sooner than MIN_PERIOD cycles after the
//   previous accepted edge, and flags loss of signal after TIMEOUT cycles.
//   Results are offered through a valid/ready handshake; an unconsumed result
//   that is overwritten raises a sticky overrun flag.
//
// Ports
//   clock_in      in   single clock, all state on its rising edge
//   reset         in   synchronous, active-high reset
//   sig_in        in   asynchronous signal to be measured
//   enable        in   measurement enable (level)
//   period        out  latest measured period, COUNT_WIDTH bits
//   period_valid  out  period holds an untransferred result
//   period_ready  in   consumer accepts the result
//   edge_strobe   out  one-cycle pulse per accepted rising edge
//   overrun       out  sticky: a pending result was overwritten
//   signal_lost   out  a timeout occurred since the last result
module period_meter #(
  parameter int unsigned COUNT_WIDTH = 16,
  parameter int unsigned MIN_PERIOD  = 8,
  parameter int unsigned TIMEOUT     = 50000
) (
  input  logic                   clock_in,
  input  logic                   reset,
  input  logic                   sig_in,
  input  logic                   enable,
  output logic [COUNT_WIDTH-1:0] period,
  output logic                   period_valid,
  input  logic                   period_ready,
  output logic                   edge_strobe,
  output logic                   overrun,
  output logic                   signal_lost
);

  localparam logic [COUNT_WIDTH-1:0] ONE       = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] MIN_COUNT = COUNT_WIDTH'(MIN_PERIOD);
  localparam logic [COUNT_WIDTH-1:0] TIMEOUT_C = COUNT_WIDTH'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMED     = 2'd1,
    MEASURING = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [COUNT_WIDTH-1:0] count;
  logic [COUNT_WIDTH-1:0] count_next;
  logic                   sync_1;
  logic                   sync_2;
  logic                   sync_3;
  logic                   rise;
  logic                   load;
  logic                   strobe_next;
  logic                   lost_set;

  assign rise = sync_2 & ~sync_3;

  always_comb begin
    state_next  = state;
    count_next  = count;
    load        = 1'b0;
    strobe_next = 1'b0;
    lost_set    = 1'b0;
    if (!enable) begin
      state_next = IDLE;
      count_next = '0;
    end else begin
      case (state)
        IDLE: state_next = ARMED;
        ARMED: begin
          if (rise) begin
            state_next  = MEASURING;
            count_next  = ONE;
            strobe_next = 1'b1;
          end
        end
        MEASURING: begin
          // An edge landing exactly on the timeout cycle still yields a
          // result, so the edge check takes priority over the timeout.
          if (rise && (count >= MIN_COUNT)) begin
            load        = 1'b1;
            count_next  = ONE;
            strobe_next = 1'b1;
          end else if (count == TIMEOUT_C) begin
            lost_set   = 1'b1;
            count_next = '0;
            state_next = ARMED;
          end else begin
            count_next = count + ONE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      state        <= IDLE;
      count        <= '0;
      sync_1       <= 1'b0;
      sync_2       <= 1'b0;
      sync_3       <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      edge_strobe  <= 1'b0;
      overrun      <= 1'b0;
      signal_lost  <= 1'b0;
    end else begin
      state       <= state_next;
      count       <= count_next;
      sync_1      <= sig_in;
      sync_2      <= sync_1;
      sync_3      <= sync_2;
      edge_strobe <= strobe_next;
      if (load) begin
        period       <= count;
        period_valid <= 1'b1;
        // Overwriting in a transfer cycle is not a loss, so only flag it
        // when the consumer is not taking the old value.
        if (period_valid && !period_ready) begin
          overrun <= 1'b1;
        end
      end else if (period_valid && period_ready) begin
        period_valid <= 1'b0;
      end
      if (load) begin
        signal_lost <= 1'b0;
      end else if (lost_set) begin
        signal_lost <= 1'b1;
      end
    end
  end

endmodule

// File: doc/period_meter.md
PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001 SHALL have parameter COUNT_WIDTH, default 16: width of the period counter and result.
REQ-002 SHALL have parameter MIN_PERIOD, default 8: edges spaced closer than this many cycles are glitches; legal range 2 to TIMEOUT.
REQ-003 SHALL have parameter TIMEOUT, default 50000: cycles without an accepted edge before loss; SHALL be less than 2^COUNT_WIDTH.
REQ-004 SHALL have port clock_in, input, 1 bit: the single clock; all state on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port sig_in, input, 1 bit: asynchronous external signal to be measured (e.g. coil feedback).
REQ-007 SHALL have port enable, input, 1 bit: measurement enable, level.
REQ-008 SHALL have port period, output, COUNT_WIDTH bits: latest measured period in clock_in cycles.
REQ-009 SHALL have port period_valid, output, 1 bit: period holds an untransferred result.
REQ-010 SHALL have port period_ready, input, 1 bit: consumer accepts the result.
REQ-011 SHALL have port edge_strobe, output, 1 bit: one-cycle pulse per accepted rising edge.
REQ-012 SHALL have port overrun, output, 1 bit: sticky; a pending result was overwritten.
REQ-013 SHALL have port signal_lost, output, 1 bit: level; a timeout occurred since the last result.

Function
REQ-014 SHALL pass sig_in through a two-flop synchronizer and a third history flop; rising edge detect = stage2 high and stage3 low.
REQ-015 SHALL assert edge_strobe, registered, for one cycle exactly 3 clock_in edges after sig_in is first sampled high, for accepted edges only.
REQ-016 SHALL implement states IDLE, ARMED, MEASURING; SHALL discard edges detected in IDLE.
REQ-017 IDLE -> ARMED when enable=1; any state -> IDLE when enable=0, with the counter cleared; period, period_valid and overrun are retained.
REQ-018 ARMED: on a detected edge, SHALL move to MEASURING, set the counter to 1 on the next cycle, and pulse edge_strobe.
REQ-019 MEASURING: SHALL increment the counter by 1 per cycle, so the counter equals the cycle distance from the previous accepted edge.
REQ-020 MEASURING, edge with counter >= MIN_PERIOD: SHALL load period from the counter, set period_valid, clear signal_lost, restart the counter at 1 and pulse edge_strobe.
REQ-021 MEASURING, edge with counter < MIN_PERIOD: SHALL ignore the edge, with no strobe, no result and the counter continuing.
REQ-022 MEASURING, counter == TIMEOUT with no edge that cycle: SHALL set signal_lost, clear the counter and go to ARMED; with an edge that same cycle, REQ-020 applies with period = TIMEOUT.
REQ-023 Handshake: a transfer occurs when period_valid and period_ready are both high; period_valid SHALL fall the next cycle unless a new result loads that cycle.
REQ-024 A new result while period_valid=1 and period_ready=0: SHALL overwrite period with the newest value, keep period_valid=1 and set overrun.
REQ-025 A new result in a transfer cycle: SHALL load the new value, keep period_valid=1 and leave overrun unchanged.
REQ-026 period SHALL not change while period_valid=1 except per REQ-024/025.
REQ-027 overrun SHALL clear only on reset.

Reset
REQ-028 On reset=1 at a clock edge: state SHALL be IDLE; counter, synchronizer and history flops SHALL be 0; period, period_valid, edge_strobe, overrun and signal_lost SHALL all be 0.
REQ-029 Reset SHALL override every other input in the same cycle, including mid-measurement and a pending result.
REQ-030 After reset, no result SHALL appear until enable=1 and two accepted edges are detected.

Verification (MIN_PERIOD=8, TIMEOUT=1000, COUNT_WIDTH=16)
REQ-031 Square wave with rising edges every 100 cycles, period_ready=1 -> period=100; period_valid one cycle per edge from the 2nd edge on; overrun=0.
REQ-032 period_ready=0, edges every 50 cycles, 3 edges -> period=50, period_valid held, overrun=1 after the 3rd edge; a one-cycle ready pulse -> period_valid=0 the next cycle.
REQ-033 Rising edges at t=0, 5 and 60 -> single result period=60; edge_strobe pulses exactly twice.
REQ-034 Edges stop after a result -> signal_lost=1 and state ARMED 1000 cycles after the last accepted edge; edges then every 200 cycles -> period=200 after the 2nd edge, signal_lost=0 that cycle.
REQ-035 reset pulsed for 1 cycle at counter=40 with period_valid=1 -> next cycle all outputs 0; the first new result only after 2 edges with enable=1.
REQ-036 enable=0 for 1 cycle mid-period, edges every 100 cycles -> that interval produces no result; the next result is 100 after two fresh edges; the prior pending result is retained.
